// File: rtl/s2_rx.sv
// s2_rx: serial column receiver. Rebuilds an 18x8 image from eight 21-bit column frames and writes it to RB2.
// Optional build macro S2_RX_FRAME_CHECK_EN: commit on frame end only for exactly 21 bits, pulse err otherwise.
module s2_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       sen,
    input  logic       sd,
    output logic       RB2_RW,
    output logic [4:0] RB2_A,
    output logic [7:0] RB2_D,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, FIN} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  col_addr;
    logic [17:0] col_data;
    logic [7:0]  mask;
    logic [4:0]  idx;
    logic [7:0]  col_buf [18];

    logic        commit;
    logic [17:0] commit_data;
    logic [7:0]  mask_next;

`ifdef S2_RX_FRAME_CHECK_EN
    // Commit waits for the frame to close so the bit count can be validated.
    logic bad_frame;
    assign commit      = (state == RECV) && sen && (cnt == 5'd21);
    assign commit_data = col_data;
    assign bad_frame   = (state == RECV) && sen && (cnt != 5'd0) && (cnt != 5'd21);
`else
    // Commit on the edge sampling bit 20, so the word-0 bit comes straight from sd.
    assign commit      = (state == RECV) && !sen && (cnt == 5'd20);
    assign commit_data = {col_data[16:0], sd};
`endif

    assign mask_next = mask | (8'd1 << col_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            col_addr <= 3'd0;
            col_data <= 18'd0;
            mask     <= 8'd0;
            idx      <= 5'd0;
            RB2_RW   <= 1'b1;
            RB2_A    <= 5'd0;
            RB2_D    <= 8'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int w = 0; w < 18; w++) begin
                col_buf[w] <= 8'd0;
            end
        end else begin
            done <= 1'b0;
`ifdef S2_RX_FRAME_CHECK_EN
            err  <= bad_frame;
`else
            err  <= 1'b0;
`endif
            // Column k lands in bit 7-k of every word; a repeated column simply overwrites.
            if (commit) begin
                for (int w = 0; w < 18; w++) begin
                    col_buf[w][~col_addr] <= commit_data[w];
                end
                mask <= mask_next;
            end

            case (state)
                IDLE: begin
                    cnt <= 5'd0;
                    if (sen) begin
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (!sen) begin
                        if (cnt != 5'd31) begin
                            cnt <= cnt + 5'd1;
                        end
                        if (cnt < 5'd3) begin
                            col_addr <= {col_addr[1:0], sd};
                        end else if (cnt <= 5'd20) begin
                            col_data <= {col_data[16:0], sd};
                        end
                    end else begin
                        cnt <= 5'd0;
                    end
                    if (commit && (mask_next == 8'hFF)) begin
                        state <= WRITE;
                        idx   <= 5'd0;
                    end
                end
                WRITE: begin
                    RB2_RW <= 1'b0;
                    RB2_A  <= idx;
                    RB2_D  <= col_buf[idx];
                    if (idx == 5'd17) begin
                        state <= FIN;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                FIN: begin
                    RB2_RW <= 1'b1;
                    done   <= 1'b1;
                    mask   <= 8'd0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s2_rx.sv
// tb_s2_rx: table-driven frame stimulus with a write scoreboard for s2_rx.
// Expected RB2 writes are derived from the image word[w] = w*13+5 and the column placement rule.
module tb_s2_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sen;
    logic       sd;
    logic       RB2_RW;
    logic [4:0] RB2_A;
    logic [7:0] RB2_D;
    logic       done;
    logic       err;

    s2_rx dut (
        .clk    (clk),
        .rst    (rst),
        .sen    (sen),
        .sd     (sd),
        .RB2_RW (RB2_RW),
        .RB2_A  (RB2_A),
        .RB2_D  (RB2_D),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         scen;
        logic [2:0] k;
        logic       inv;
        int         nbits;
        logic       lost;
        logic       done_exp;
    } frame_t;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    frame_t     vec[$];
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] model_buf [18];
    int         checks      = 0;
    int         failures    = 0;
    int         done_count  = 0;
    int         err_count   = 0;
    int         write_count = 0;

    function automatic logic [7:0] baseImg(input int w);
        return 8'(w * 13 + 5);
    endfunction

    function automatic logic frameCommits(input int nbits);
`ifdef S2_RX_FRAME_CHECK_EN
        return nbits == 21;
`else
        return nbits >= 21;
`endif
    endfunction

    function automatic int expectedErrs();
`ifdef S2_RX_FRAME_CHECK_EN
        return 2;
`else
        return 0;
`endif
    endfunction

    function automatic int expectedLatency();
`ifdef S2_RX_FRAME_CHECK_EN
        return 3;
`else
        return 2;
`endif
    endfunction

    task automatic addRow(input int scen, input logic [2:0] k, input logic inv, input int nbits,
                          input logic lost, input logic done_exp);
        frame_t f;
        f.scen = scen; f.k = k; f.inv = inv; f.nbits = nbits; f.lost = lost; f.done_exp = done_exp;
        vec.push_back(f);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rw"},   RB2_RW, 1);
        checkOutput({tag, "_addr"}, RB2_A,  0);
        checkOutput({tag, "_data"}, RB2_D,  0);
        checkOutput({tag, "_done"}, done,   0);
        checkOutput({tag, "_err"},  err,    0);
    endtask

    // Drives one frame with a one-cycle sen=1 gap after it; returns just after the edge sampling the last bit.
    task automatic sendFrame(input logic [2:0] k, input logic [17:0] colv, input int nbits);
        logic [2:0]  kk;
        logic [17:0] cc;
        kk = k;
        cc = colv;
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            #1;
            sen = 1'b0;
            if (i < 3) begin
                sd = kk[2];
                kk = kk << 1;
            end else if (i < 21) begin
                sd = cc[17];
                cc = cc << 1;
            end else begin
                sd = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        sen = 1'b1;
        sd  = 1'b0;
    endtask

    task automatic applyStimulus(input frame_t f);
        logic [17:0] colv;
        logic [7:0]  b;
        for (int w = 0; w < 18; w++) begin
            b       = baseImg(w);
            colv[w] = b[3'd7 - f.k] ^ f.inv;
        end
        if (!f.lost && frameCommits(f.nbits)) begin
            for (int w = 0; w < 18; w++) begin
                model_buf[w][3'd7 - f.k] = colv[w];
            end
        end
        if (f.done_exp) begin
            for (int w = 0; w < 18; w++) begin
                exp_q.push_back('{5'(w), model_buf[w]});
            end
        end
        sendFrame(f.k, colv, f.nbits);
    endtask

    task automatic runScenario(input int s);
        foreach (vec[i]) begin
            if (vec[i].scen == s) begin
                applyStimulus(vec[i]);
            end
        end
    endtask

    task automatic waitDone(input int expected, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (done_count >= expected) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checkOutput("done_count", done_count, expected);
        checkOutput("queue_empty", exp_q.size(), 0);
    endtask

    // Scoreboard: every RB2 write must match the next expected word.
    always @(negedge clk) begin
        if (RB2_RW == 1'b0) begin
            write_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %0d, expected no write", RB2_A, RB2_D);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("wr_addr", RB2_A, mon_e.addr);
                checkOutput("wr_data", RB2_D, mon_e.data);
            end
        end
        if (done) done_count++;
        if (err)  err_count++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int dly;
        logic [17:0] c3;
        logic [7:0]  b;

        // Scenario 1: in-order pass; 2: out-of-order with duplicate; 3: continuous upstream loop;
        // 4: pass after mid-frame reset (inverted image); 5: short and long frames.
        for (int k = 0; k < 8; k++) addRow(1, 3'(k), 1'b0, 21, 1'b0, k == 7);
        addRow(2, 3'd5, 1'b0, 21, 1'b0, 1'b0);
        addRow(2, 3'd2, 1'b0, 21, 1'b0, 1'b0);
        addRow(2, 3'd2, 1'b1, 21, 1'b0, 1'b0);
        addRow(2, 3'd0, 1'b0, 21, 1'b0, 1'b0);
        addRow(2, 3'd1, 1'b0, 21, 1'b0, 1'b0);
        addRow(2, 3'd3, 1'b0, 21, 1'b0, 1'b0);
        addRow(2, 3'd4, 1'b0, 21, 1'b0, 1'b0);
        addRow(2, 3'd6, 1'b0, 21, 1'b0, 1'b0);
        addRow(2, 3'd7, 1'b0, 21, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) addRow(3, 3'(k), 1'b0, 21, 1'b0, k == 7);
        for (int k = 0; k < 8; k++) addRow(3, 3'(k), 1'b0, 21, k == 0, 1'b0);
        for (int k = 0; k < 8; k++) addRow(3, 3'(k), 1'b0, 21, k == 1, k == 0);
        for (int k = 0; k < 8; k++) addRow(4, 3'(k), 1'b1, 21, 1'b0, k == 7);
        for (int k = 0; k < 7; k++) addRow(5, 3'(k), 1'b0, 21, 1'b0, 1'b0);
        addRow(5, 3'd7, 1'b1, 20, 1'b0, 1'b0);
`ifdef S2_RX_FRAME_CHECK_EN
        addRow(5, 3'd7, 1'b1, 22, 1'b0, 1'b0);
        addRow(5, 3'd7, 1'b0, 21, 1'b0, 1'b1);
`else
        addRow(5, 3'd7, 1'b0, 22, 1'b0, 1'b1);
`endif

        for (int w = 0; w < 18; w++) model_buf[w] = 8'd0;
        rst = 1'b1;
        sen = 1'b1;
        sd  = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] scenario 1: in-order full pass");
        runScenario(1);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (RB2_RW == 1'b0) begin
                lat = n;
                break;
            end
        end
        checkOutput("first_write_latency", lat, expectedLatency());
        dly = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                dly = n;
                break;
            end
        end
        checkOutput("done_delay", dly, 18);
        checkOutput("rw_at_done", RB2_RW, 1);
        checkOutput("addr_hold_at_done", RB2_A, 17);
        @(negedge clk);
        checkOutput("done_width", done, 0);
        waitDone(1, 60);

        $display("[TB] scenario 2: out-of-order and duplicate column");
        runScenario(2);
        waitDone(2, 60);

        $display("[TB] scenario 3: frames during write-out");
        runScenario(3);
        waitDone(4, 60);

        $display("[TB] scenario 4: reset at bit 10 of column 3");
        for (int w = 0; w < 18; w++) begin
            b     = baseImg(w);
            c3[w] = b[4];
        end
        sendFrame(3'd3, c3, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            sen = 1'b0;
            sd  = (i < 3) ? ((i == 0) ? 1'b0 : 1'b1) : c3[20 - i];
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkReset("rst_mid");
        @(posedge clk);
        #1;
        sen = 1'b1;
        @(negedge clk);
        checkReset("rst_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int w = 0; w < 18; w++) model_buf[w] = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        runScenario(4);
        waitDone(5, 60);

        $display("[TB] scenario 5: short and long frames");
        runScenario(5);
        waitDone(6, 60);
        checkOutput("err_count", err_count, expectedErrs());
        checkOutput("total_writes", write_count, 6 * 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
